// File: rtl/joy_scan_pkg.sv
// Shared definitions for the DB9 joystick scanner: scan states, pad-word
// bit positions and the length of the 74HC165 chain.
package joy_scan_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        DONE,
        GAPW
    } scan_state_t;

    localparam int unsigned JOY_RIGHT = 0;
    localparam int unsigned JOY_LEFT  = 1;
    localparam int unsigned JOY_DOWN  = 2;
    localparam int unsigned JOY_UP    = 3;
    localparam int unsigned JOY_B     = 4;
    localparam int unsigned JOY_C     = 5;
    localparam int unsigned JOY_A     = 6;
    localparam int unsigned JOY_START = 7;

    localparam int unsigned CHAIN = 16;

endpackage

// File: rtl/joy_debounce.sv
// Debounces complete pad candidates: outputs change only after DEB identical
// candidates in a row, with a one-clock upd pulse on every change.
module joy_debounce #(
    parameter int unsigned DEB = 3,
    parameter int unsigned W   = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] cand,
    output logic [W-1:0] q,
    output logic         upd
);

    localparam int unsigned   CW    = $clog2(DEB + 1);
    localparam logic [CW-1:0] DEB_C = CW'(DEB);

    logic [W-1:0]  prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        if (cand != prev) begin
            cnt_nxt = CW'(1);
        end else if (cnt == DEB_C) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev <= '0;
            cnt  <= '0;
            q    <= '0;
            upd  <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (valid) begin
                prev <= cand;
                cnt  <= cnt_nxt;
                if (cnt_nxt == DEB_C && cand != q) begin
                    q   <= cand;
                    upd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/joy_scan.sv
// Two-port DB9 joystick scanner over a 16-bit 74HC165 chain, with Mega
// Drive select multiplexing and debounced active-high pad words.
module joy_scan
    import joy_scan_pkg::*;
#(
    parameter int unsigned CKDIV = 8,
    parameter int unsigned GAP   = 15,
    parameter int unsigned DEB   = 3
) (
    input  logic       clock,
    input  logic       reset,
    output logic       joyCk,
    output logic       joyLd,
    output logic       joyS,
    input  logic       joyD,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       upd
);

    localparam int unsigned DW = $clog2(CKDIV);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned KW = $clog2(CHAIN);

    scan_state_t   st;
    logic [DW-1:0] div;
    logic [GW-1:0] gcnt;
    logic [KW-1:0] k;
    logic          h;
    logic          tick;
    logic          done_lo;
    logic [5:0]    s1, s2, hi1, hi2;
    logic [7:0]    c1, c2;
    logic [15:0]   q;

    // Outputs are registered for the tick interval that follows, so the
    // chain sees joyD sampled at the end of each even (joyCk=0) interval.
    always_comb begin
        tick    = (div == DW'(CKDIV - 1));
        done_lo = tick && (st == DONE) && !joyS;
        c1 = '0;
        c2 = '0;
        c1[JOY_C:JOY_RIGHT] = hi1;
        c2[JOY_C:JOY_RIGHT] = hi2;
        c1[JOY_A]     = s1[4];
        c1[JOY_START] = s1[5];
        c2[JOY_A]     = s2[4];
        c2[JOY_START] = s2[5];
        joy1 = q[15:8];
        joy2 = q[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st    <= LOAD;
            div   <= '0;
            gcnt  <= '0;
            k     <= '0;
            h     <= 1'b0;
            s1    <= '0;
            s2    <= '0;
            hi1   <= '0;
            hi2   <= '0;
            joyCk <= 1'b0;
            joyLd <= 1'b1;
            joyS  <= 1'b1;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                case (st)
                    LOAD: begin
                        joyLd <= 1'b0;
                        joyCk <= 1'b0;
                        k     <= '0;
                        h     <= 1'b0;
                        st    <= SHIFT;
                    end
                    SHIFT: begin
                        joyLd <= 1'b1;
                        if (!h) begin
                            joyCk <= 1'b0;
                            h     <= 1'b1;
                        end else begin
                            // Chain bits 6,7,14,15 carry nothing useful.
                            if (k[2:0] < 3'd6) begin
                                if (k[3]) s2[k[2:0]] <= ~joyD;
                                else      s1[k[2:0]] <= ~joyD;
                            end
                            joyCk <= 1'b1;
                            h     <= 1'b0;
                            if (k == KW'(CHAIN - 1)) st <= DONE;
                            else                     k  <= k + 1'b1;
                        end
                    end
                    DONE: begin
                        joyCk <= 1'b0;
                        joyS  <= ~joyS;
                        if (joyS) begin
                            hi1 <= s1;
                            hi2 <= s2;
                        end
                        gcnt <= '0;
                        st   <= (GAP == 0) ? LOAD : GAPW;
                    end
                    GAPW: begin
                        if (gcnt == GW'(GAP - 1)) st <= LOAD;
                        else                      gcnt <= gcnt + 1'b1;
                    end
                    default: st <= LOAD;
                endcase
            end
        end
    end

    joy_debounce #(
        .DEB(DEB),
        .W  (16)
    ) u_deb (
        .clock(clock),
        .reset(reset),
        .valid(done_lo),
        .cand ({c1, c2}),
        .q    (q),
        .upd  (upd)
    );

endmodule

// File: tb/tb_joy_scan.sv
// Bench for joy_scan: two instances (default and fast) behind 74HC165 chain
// models, with a model-fed scoreboard checked at each completed select pair.
module tb_joy_scan;

    localparam int unsigned CKDIV0 = 8;
    localparam int unsigned GAP0   = 15;
    localparam int unsigned DEB0   = 3;
    localparam int unsigned CKDIV1 = 2;
    localparam int unsigned GAP1   = 0;
    localparam int unsigned DEB1   = 1;

    typedef struct packed {
        logic        u;
        logic [15:0] w;
    } exp_t;

    typedef struct packed {
        logic [15:0] cand;
        logic [15:0] out;
        logic [7:0]  cnt;
    } mdl_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic       ck0, ld0, s0, d0, upd0;
    logic       ck1, ld1, s1, d1, upd1;
    logic [7:0] j10, j20, j11, j21;

    joy_scan #(.CKDIV(CKDIV0), .GAP(GAP0), .DEB(DEB0)) u0 (
        .clock(clock), .reset(reset), .joyCk(ck0), .joyLd(ld0), .joyS(s0),
        .joyD(d0), .joy1(j10), .joy2(j20), .upd(upd0)
    );

    joy_scan #(.CKDIV(CKDIV1), .GAP(GAP1), .DEB(DEB1)) u1 (
        .clock(clock), .reset(reset), .joyCk(ck1), .joyLd(ld1), .joyS(s1),
        .joyD(d1), .joy1(j11), .joy2(j21), .upd(upd1)
    );

    // Pad images are active-high per chain position; the chain carries them inverted.
    logic [15:0] ihi0 = '0, ilo0 = '0, ihi1 = '0, ilo1 = '0;
    logic [15:0] ch0, ch1;
    logic        pc0, pc1;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ch0 <= '1; pc0 <= 1'b0;
        end else begin
            pc0 <= ck0;
            if (!ld0)              ch0 <= s0 ? ~ihi0 : ~ilo0;
            else if (ck0 && !pc0)  ch0 <= {1'b1, ch0[15:1]};
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ch1 <= '1; pc1 <= 1'b0;
        end else begin
            pc1 <= ck1;
            if (!ld1)              ch1 <= s1 ? ~ihi1 : ~ilo1;
            else if (ck1 && !pc1)  ch1 <= {1'b1, ch1[15:1]};
        end
    end

    assign d0 = ch0[0];
    assign d1 = ch1[0];

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    mdl_t m0 = '0;
    mdl_t m1 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] cand_of(input logic [15:0] hi, input logic [15:0] lo);
        return {lo[5], lo[4], hi[5:0], lo[13], lo[12], hi[13:8]};
    endfunction

    task automatic model_step(inout mdl_t m, input logic [15:0] c, input int unsigned deb,
                              output logic u);
        if (c == m.cand) begin
            if (m.cnt < deb) m.cnt++;
        end else begin
            m.cand = c;
            m.cnt  = 1;
        end
        u = (m.cnt == deb) && (c != m.out);
        if (u) m.out = c;
    endtask

    // Monitors: sample on the falling edge, score each completed pair.
    int   pairs0 = 0, pairs1 = 0, scans0 = 0, ckc0 = 0, stray0 = 0, stray1 = 0;
    logic p_s0 = 1'b1, p_ld0 = 1'b1, p_c0 = 1'b0, started0 = 1'b0, exp_s0 = 1'b1;
    logic p_s1 = 1'b1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                p_s0 = 1'b1; p_ld0 = 1'b1; p_c0 = 1'b0;
                started0 = 1'b0; exp_s0 = 1'b1; ckc0 = 0;
            end else begin
                if (ck0 && !p_c0) ckc0++;
                if (!ld0 && p_ld0) begin
                    if (started0) check("ck_edges", ckc0, 16);
                    check("sel_at_load", s0, exp_s0);
                    exp_s0 = !exp_s0;
                    ckc0 = 0;
                    started0 = 1'b1;
                    scans0++;
                end
                if (s0 && !p_s0) begin
                    if (q0.size() > 0) begin
                        e = q0.pop_front();
                        check("upd0", upd0, e.u);
                        check("word0", {j10, j20}, e.w);
                    end else begin
                        check("upd0_idle", upd0, 0);
                    end
                    pairs0++;
                end else if (upd0) begin
                    stray0++;
                end
                p_s0 = s0; p_ld0 = ld0; p_c0 = ck0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                p_s1 = 1'b1;
            end else begin
                if (s1 && !p_s1) begin
                    if (q1.size() > 0) begin
                        e = q1.pop_front();
                        check("upd1", upd1, e.u);
                        check("word1", {j11, j21}, e.w);
                    end else begin
                        check("upd1_idle", upd1, 0);
                    end
                    pairs1++;
                end else if (upd1) begin
                    stray1++;
                end
                p_s1 = s1;
            end
        end
    end

    task automatic run_pair0(input logic [15:0] hi, input logic [15:0] lo);
        exp_t e;
        logic u, got;
        int   start;
        ihi0 = hi;
        ilo0 = lo;
        model_step(m0, cand_of(hi, lo), DEB0, u);
        e.u = u;
        e.w = m0.out;
        q0.push_back(e);
        start = pairs0;
        got = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clock);
            if (pairs0 != start) begin got = 1'b1; break; end
        end
        check("pair0_wait", got, 1);
    endtask

    task automatic wait_pair1(output logic got);
        int start;
        start = pairs1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (pairs1 != start) begin got = 1'b1; break; end
        end
    endtask

    task automatic run_pair1(input logic [15:0] hi, input logic [15:0] lo);
        exp_t e;
        logic u, got;
        ihi1 = hi;
        ilo1 = lo;
        model_step(m1, cand_of(hi, lo), DEB1, u);
        e.u = u;
        e.w = m1.out;
        q1.push_back(e);
        wait_pair1(got);
        check("pair1_wait", got, 1);
    endtask

    task automatic release_and_time();
        int n;
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clock);
            #1;
            if (!ld0) begin n = i; break; end
        end
        check("ld_latency", n, CKDIV0);
    endtask

    initial begin
        logic got;
        int   start;

        repeat (2) @(negedge clock);
        check("rst_ck", ck0, 0);
        check("rst_ld", ld0, 1);
        check("rst_sel", s0, 1);
        check("rst_joy1", j10, 0);
        check("rst_joy2", j20, 0);
        check("rst_upd", upd0, 0);
        release_and_time();

        repeat (2) run_pair0(16'h0000, 16'h0000);
        check("idle_joy", {j10, j20}, 16'h0000);

        // pad 1: right in select-high phase, start in select-low phase
        repeat (3) run_pair0(16'h0001, 16'h0020);
        check("pad1_joy1", j10, 8'h81);
        check("pad1_joy2", j20, 8'h00);

        // pad 2 up + C held, pad 1 still held
        repeat (3) run_pair0(16'h2801, 16'h0820);
        check("pad2_joy1", j10, 8'h81);
        check("pad2_joy2", j20, 8'h28);

        repeat (3) run_pair0(16'h0000, 16'h0000);
        check("release_joy", {j10, j20}, 16'h0000);

        // single-pair glitch on B must be filtered
        run_pair0(16'h0010, 16'h0000);
        repeat (3) run_pair0(16'h0000, 16'h0000);
        check("glitch_joy1", j10, 8'h00);
        repeat (3) run_pair0(16'h0010, 16'h0000);
        check("held_joy1", j10, 8'h10);

        // reset during the select-low scan, k = 7
        ihi0 = 16'h0010;
        ilo0 = 16'h0010;
        start = scans0;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (scans0 >= start + 2 && ckc0 == 7) begin got = 1'b1; break; end
        end
        check("mid_wait", got, 1);
        check("mid_pre_sel", s0, 0);
        check("mid_pre_ck", ck0, 1);
        reset = 1'b0;
        #1;
        check("mid_ck", ck0, 0);
        check("mid_ld", ld0, 1);
        check("mid_sel", s0, 1);
        check("mid_joy1", j10, 0);
        check("mid_upd", upd0, 0);
        m0 = '0;
        m1 = '0;
        ihi0 = '0;
        ilo0 = '0;
        repeat (2) @(negedge clock);
        release_and_time();
        repeat (2) run_pair0(16'h0000, 16'h0000);

        // fast instance, DEB = 1: every changed pair updates
        wait_pair1(got);
        check("sync1", got, 1);
        run_pair1(16'h0001, 16'h0000);
        run_pair1(16'h0000, 16'h0000);
        run_pair1(16'h0100, 16'h0020);
        check("fast_joy1", j11, 8'h80);
        check("fast_joy2", j21, 8'h01);
        run_pair1(16'h0000, 16'h0000);

        check("stray0", stray0, 0);
        check("stray1", stray1, 0);
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
